// File: rtl/chip_link_tx_if.sv
// Router-egress packet handshake plus the 4-phase flit link of one chip_link_tx port.
// The master modport is the transmitter's view; the slave modport is router plus remote receiver.
interface chip_link_tx_if #(
  parameter int CHIPDATA_WIDTH = 16,
  parameter int PKT_WIDTH      = 64
);
  logic [PKT_WIDTH-1:0]      pkt_data;
  logic                      pkt_valid;
  logic                      pkt_ready;
  logic [CHIPDATA_WIDTH-1:0] send_data_out;
  logic                      send_data_valid;
  logic                      send_data_par;
  logic                      send_data_ready;
  logic                      send_data_err;
  logic                      pkt_sent;
  logic                      link_err;

  modport master (
    input  pkt_data, pkt_valid, send_data_ready, send_data_err,
    output pkt_ready, send_data_out, send_data_valid, send_data_par, pkt_sent, link_err
  );

  modport slave (
    output pkt_data, pkt_valid, send_data_ready, send_data_err,
    input  pkt_ready, send_data_out, send_data_valid, send_data_par, pkt_sent, link_err
  );
endinterface

// File: rtl/chip_link_tx.sv
// Inter-chip link transmitter: serialises one packet MSB-first into even-parity flits,
// each sent with a 4-phase valid/ready handshake, retrying parity-rejected flits.
module chip_link_tx #(
  parameter int CHIPDATA_WIDTH = 16,
  parameter int PKT_WIDTH      = 64,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT        = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  chip_link_tx_if.master  link
);

  localparam int NFLIT = PKT_WIDTH / CHIPDATA_WIDTH;
  localparam int IDX_W = (NFLIT > 1) ? $clog2(NFLIT) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WLOW, S_HOLD, S_REL} state_t;

  function automatic logic f_even_par(input logic [CHIPDATA_WIDTH-1:0] d);
    return ^d;
  endfunction

  state_t                    r_state;
  logic [PKT_WIDTH-1:0]      r_pkt;
  logic [IDX_W-1:0]          r_flit_idx;
  logic [RTY_W-1:0]          r_retry;
  logic [TMO_W-1:0]          r_tmo;
  logic                      r_nack;
  logic                      r_pkt_ready;
  logic [CHIPDATA_WIDTH-1:0] r_data;
  logic                      r_valid;
  logic                      r_par;
  logic                      r_sent;
  logic                      r_err;

  logic [CHIPDATA_WIDTH-1:0] w_flit;
  logic [PKT_WIDTH-1:0]      w_pkt_next;
  logic [CHIPDATA_WIDTH-1:0] w_flit_next;
  logic                      w_last;
  logic                      w_evt;
  logic                      w_tmo_hit;

  // r_pkt is kept left-aligned: the flit in flight is always its top slice
  assign w_flit      = r_pkt[PKT_WIDTH-1 -: CHIPDATA_WIDTH];
  assign w_pkt_next  = r_pkt << CHIPDATA_WIDTH;
  assign w_flit_next = w_pkt_next[PKT_WIDTH-1 -: CHIPDATA_WIDTH];
  assign w_last      = (r_flit_idx == IDX_W'(NFLIT - 1));
  assign w_tmo_hit   = (r_tmo == TMO_W'(TIMEOUT - 1));

  // The receiver edge each waiting state is looking for
  always_comb begin
    w_evt = 1'b0;
    case (r_state)
      S_WLOW:  w_evt = !link.send_data_ready;
      S_HOLD:  w_evt = link.send_data_ready;
      S_REL:   w_evt = !link.send_data_ready;
      default: w_evt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_flit_idx  <= '0;
      r_retry     <= '0;
      r_tmo       <= '0;
      r_nack      <= 1'b0;
      r_pkt_ready <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_par       <= 1'b0;
      r_sent      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_sent <= 1'b0;
      r_err  <= 1'b0;
      if (r_state != S_IDLE && !w_evt) begin
        // Stalled receiver: the count expires TIMEOUT cycles after the state was entered
        if (w_tmo_hit) begin
          r_valid     <= 1'b0;
          r_err       <= 1'b1;
          r_pkt_ready <= 1'b1;
          r_tmo       <= '0;
          r_state     <= S_IDLE;
        end else begin
          r_tmo <= r_tmo + TMO_W'(1);
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            r_pkt_ready <= 1'b1;
            if (link.pkt_valid && r_pkt_ready) begin
              r_pkt       <= link.pkt_data;
              r_flit_idx  <= '0;
              r_retry     <= '0;
              r_tmo       <= '0;
              r_pkt_ready <= 1'b0;
              r_state     <= S_WLOW;
            end
          end
          S_WLOW: begin
            r_data  <= w_flit;
            r_par   <= f_even_par(w_flit);
            r_valid <= 1'b1;
            r_tmo   <= '0;
            r_state <= S_HOLD;
          end
          S_HOLD: begin
            r_nack  <= link.send_data_err;
            r_valid <= 1'b0;
            r_tmo   <= '0;
            r_state <= S_REL;
          end
          S_REL: begin
            r_tmo <= '0;
            if (!r_nack && w_last) begin
              r_sent      <= 1'b1;
              r_pkt_ready <= 1'b1;
              r_state     <= S_IDLE;
            end else if (!r_nack) begin
              r_pkt      <= w_pkt_next;
              r_flit_idx <= r_flit_idx + IDX_W'(1);
              r_retry    <= '0;
              r_data     <= w_flit_next;
              r_par      <= f_even_par(w_flit_next);
              r_valid    <= 1'b1;
              r_state    <= S_HOLD;
            end else if (r_retry != RTY_W'(MAX_RETRY)) begin
              r_retry <= r_retry + RTY_W'(1);
              r_valid <= 1'b1;
              r_state <= S_HOLD;
            end else begin
              r_err       <= 1'b1;
              r_pkt_ready <= 1'b1;
              r_state     <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign link.pkt_ready       = r_pkt_ready;
  assign link.send_data_out   = r_data;
  assign link.send_data_valid = r_valid;
  assign link.send_data_par   = r_par;
  assign link.pkt_sent        = r_sent;
  assign link.link_err        = r_err;

endmodule

// File: tb/tb_chip_link_tx.sv
// Randomised bench for chip_link_tx: a 4-phase receiver model with scripted rejects,
// checked against a packet-level model of the expected flit stream and outcome.
module tb_chip_link_tx;
  localparam int CW = 16;
  localparam int PW = 64;
  localparam int MAX_RETRY = 3;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  chip_link_tx_if #(.CHIPDATA_WIDTH(CW), .PKT_WIDTH(PW)) link();

  chip_link_tx #(
    .CHIPDATA_WIDTH(CW), .PKT_WIDTH(PW), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .link (link)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad = 0;

  logic rx_stall = 1'b0;
  logic man_ready = 1'b0;
  logic man_err = 1'b0;
  logic rx_ready = 1'b0;
  logic rx_err = 1'b0;
  int rx_lat = 1;
  int rx_base = 0;
  int rx_att = 0;
  int rx_st = 0;
  int rx_cnt = 0;
  logic [15:0] rx_nack = '0;
  logic [CW-1:0] rx_cap;
  logic [CW-1:0] obs_q[$];
  logic obsp_q[$];
  logic [CW-1:0] exp_q[$];
  int sent_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int unstable_cnt = 0;

  assign link.send_data_ready = rx_stall ? man_ready : rx_ready;
  assign link.send_data_err   = rx_stall ? man_err : rx_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Remote receiver and pulse monitor, all sampled on the falling edge
  initial begin
    int idx;
    forever begin
      @(negedge clk);
      if (link.pkt_sent) sent_cnt++;
      if (link.link_err) err_cnt++;
      if (link.pkt_sent && link.link_err) both_cnt++;
      if (!rx_stall) begin
        case (rx_st)
          0: if (link.send_data_valid) begin
               rx_cap = link.send_data_out;
               obs_q.push_back(rx_cap);
               obsp_q.push_back(link.send_data_par);
               rx_cnt = rx_lat;
               rx_st = 1;
             end
          1: if (rx_cnt > 0) rx_cnt--;
             else begin
               if (link.send_data_out !== rx_cap || !link.send_data_valid) unstable_cnt++;
               idx = rx_att - rx_base;
               rx_err = (idx >= 0 && idx < 16) ? rx_nack[idx] : 1'b0;
               rx_ready = 1'b1;
               rx_att++;
               rx_st = 2;
             end
          2: if (!link.send_data_valid) begin
               rx_cnt = rx_lat;
               rx_st = 3;
             end
          3: if (rx_cnt > 0) rx_cnt--;
             else begin
               rx_ready = 1'b0;
               rx_err = 1'b0;
               rx_st = 0;
             end
          default: rx_st = 0;
        endcase
      end
    end
  end

  // Packet-level reference: flit k is the k-th 16-bit slice from the top; attempt a is
  // rejected when nack[a] is set; a flit gets 1+MAX_RETRY attempts before the packet is dropped
  task automatic model_pkt(input logic [63:0] pkt, input logic [15:0] nack, input int a0,
                           output bit ok, output int a_end);
    int a;
    int r;
    bit nk;
    logic [63:0] tmp;
    a = a0;
    ok = 1'b1;
    for (int k = 0; k < PW / CW; k++) begin
      tmp = pkt >> (CW * (PW / CW - 1 - k));
      r = 0;
      forever begin
        exp_q.push_back(tmp[CW-1:0]);
        nk = (a - a0 < 16) ? nack[a - a0] : 1'b0;
        a++;
        if (!nk) break;
        if (r == MAX_RETRY) begin
          ok = 1'b0;
          break;
        end
        r++;
      end
      if (!ok) break;
    end
    a_end = a;
  endtask

  task automatic cmp_flits(input string tag, input int ob);
    chk({tag, "_nflits"}, obs_q.size() - ob, exp_q.size());
    for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
      chk({tag, "_flit"}, obs_q[ob + i], exp_q[i]);
      chk({tag, "_par"}, obsp_q[ob + i], ^exp_q[i]);
    end
  endtask

  task automatic wait_pulse(input string tag, input int budget);
    int n;
    n = 0;
    while (!(link.pkt_sent || link.link_err) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk({tag, "_pulse_timeout"}, 0, 1);
  endtask

  task automatic run_pkt(input string tag, input logic [63:0] pkt, input logic [15:0] nack,
                         input int lat);
    bit ok;
    int a_end;
    int ob;
    int sb;
    int n;
    exp_q.delete();
    model_pkt(pkt, nack, 0, ok, a_end);
    @(negedge clk);
    ob = obs_q.size();
    sb = sent_cnt + err_cnt;
    rx_base = rx_att;
    rx_nack = nack;
    rx_lat = lat;
    link.pkt_data = pkt;
    link.pkt_valid = 1'b1;
    n = 0;
    while (!link.pkt_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_idle"}, link.pkt_ready, 1);
    @(negedge clk);
    link.pkt_valid = 1'b0;
    link.pkt_data = {$urandom, $urandom};
    chk({tag, "_ready_busy"}, link.pkt_ready, 0);
    wait_pulse(tag, 3000);
    chk({tag, "_sent"}, link.pkt_sent, ok);
    chk({tag, "_lerr"}, link.link_err, !ok);
    chk({tag, "_ready_after"}, link.pkt_ready, 1);
    repeat (3) @(negedge clk);
    chk({tag, "_npulse"}, sent_cnt + err_cnt - sb, 1);
    cmp_flits(tag, ob);
  endtask

  initial begin
    logic [63:0] pkt;
    logic [15:0] nack;
    bit ok;
    int a_end;
    int ob;
    int sb;
    int n;
    int early;
    link.pkt_valid = 1'b0;
    link.pkt_data = '0;

    repeat (3) @(negedge clk);
    chk("rst_pkt_ready", link.pkt_ready, 0);
    chk("rst_valid", link.send_data_valid, 0);
    chk("rst_data", link.send_data_out, 0);
    chk("rst_par", link.send_data_par, 0);
    chk("rst_sent", link.pkt_sent, 0);
    chk("rst_lerr", link.link_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready_rise", link.pkt_ready, 1);

    // Known packet, clean acks
    pkt = 64'h0001_FFFF_8000_00FF;
    ob = obs_q.size();
    run_pkt("t1", pkt, 16'h0000, 1);
    if (obs_q.size() >= ob + 4) begin
      chk("t1_f0", obs_q[ob], 16'h0001);
      chk("t1_f1", obs_q[ob + 1], 16'hFFFF);
      chk("t1_f2", obs_q[ob + 2], 16'h8000);
      chk("t1_f3", obs_q[ob + 3], 16'h00FF);
      chk("t1_p0", obsp_q[ob], 1);
      chk("t1_p1", obsp_q[ob + 1], 0);
      chk("t1_p2", obsp_q[ob + 2], 1);
      chk("t1_p3", obsp_q[ob + 3], 0);
    end else chk("t1_count", obs_q.size() - ob, 4);

    // Single reject on flit 2, then every flit-0 attempt rejected, then a normal packet
    run_pkt("t2", pkt, 16'h0004, 1);
    run_pkt("t3", pkt, 16'h000F, 1);
    run_pkt("t3b", 64'h1234_5678_9ABC_DEF0, 16'h0000, 2);

    // Receiver never raises ready
    @(negedge clk);
    rx_stall = 1'b1;
    man_ready = 1'b0;
    link.pkt_data = 64'hCAFE_0000_0000_0001;
    link.pkt_valid = 1'b1;
    @(negedge clk);
    link.pkt_valid = 1'b0;
    n = 0;
    while (!link.send_data_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t4_valid_up", link.send_data_valid, 1);
    n = 0;
    while (link.send_data_valid && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk("t4_tmo_cycles", n, TIMEOUT);
    chk("t4_lerr", link.link_err, 1);
    chk("t4_ready", link.pkt_ready, 1);

    // Reset during the hold of flit 1
    @(negedge clk);
    link.pkt_data = pkt;
    link.pkt_valid = 1'b1;
    @(negedge clk);
    link.pkt_valid = 1'b0;
    n = 0;
    while (!link.send_data_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    man_ready = 1'b1;
    n = 0;
    while (link.send_data_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    man_ready = 1'b0;
    n = 0;
    while (!link.send_data_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_flit1", link.send_data_out, 16'hFFFF);
    sb = sent_cnt + err_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_valid", link.send_data_valid, 0);
    chk("t5_data", link.send_data_out, 0);
    chk("t5_par", link.send_data_par, 0);
    chk("t5_ready", link.pkt_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_ready_rise", link.pkt_ready, 1);
    repeat (4) @(negedge clk);
    chk("t5_no_pulse", sent_cnt + err_cnt - sb, 0);
    rx_stall = 1'b0;

    // Randomised packets, latencies and reject patterns
    for (int i = 0; i < 24; i++) begin
      pkt = {$urandom, $urandom};
      for (int b = 0; b < 16; b++) nack[b] = ($urandom_range(0, 4) == 0);
      if (i % 8 == 7) nack[7:4] = 4'hF;
      run_pkt("rnd", pkt, nack, $urandom_range(0, 3));
    end

    // Back-to-back with pkt_valid held
    exp_q.delete();
    pkt = {$urandom, $urandom};
    model_pkt(pkt, 16'h0000, 0, ok, a_end);
    @(negedge clk);
    ob = obs_q.size();
    sb = sent_cnt;
    rx_base = rx_att;
    rx_nack = 16'h0000;
    rx_lat = 1;
    link.pkt_data = pkt;
    link.pkt_valid = 1'b1;
    chk("t6_ready_a", link.pkt_ready, 1);
    @(negedge clk);
    early = 0;
    n = 0;
    while (!link.pkt_sent && n < 2000) begin
      if (link.pkt_ready) early++;
      @(negedge clk);
      n++;
    end
    chk("t6_sent_a", link.pkt_sent, 1);
    pkt = {$urandom, $urandom};
    model_pkt(pkt, 16'h0000, 0, ok, a_end);
    link.pkt_data = pkt;
    @(negedge clk);
    chk("t6_accept_b", link.pkt_ready, 0);
    link.pkt_valid = 1'b0;
    n = 0;
    while (!link.pkt_sent && n < 2000) begin
      if (link.pkt_ready) early++;
      @(negedge clk);
      n++;
    end
    chk("t6_sent_b", link.pkt_sent, 1);
    repeat (3) @(negedge clk);
    chk("t6_early_ready", early, 0);
    chk("t6_npulse", sent_cnt - sb, 2);
    cmp_flits("t6", ob);

    chk("excl_pulses", both_cnt, 0);
    chk("flit_stable", unstable_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
